// File: rtl/sd_cmd_sequencer_if.sv
// Register-port bus between sd_cmd_sequencer (master) and the SD host
// controller's CPU register interface (slave).
//
// Handshake: req=1 marks exactly one register access in that cycle. There is
// no back-pressure, so every access completes in its own cycle. reg_wr_en
// selects a write (1) or a read (0) and means nothing while req=0. Read data
// is valid on reg_rd_data exactly one cycle after the read request.
interface sd_cmd_sequencer_if;
    logic        req;
    logic        reg_wr_en;
    logic [11:0] reg_address;
    logic [31:0] reg_wr_data;
    logic [31:0] reg_rd_data;

    modport master (
        output req, reg_wr_en, reg_address, reg_wr_data,
        input  reg_rd_data
    );

    modport slave (
        input  req, reg_wr_en, reg_address, reg_wr_data,
        output reg_rd_data
    );
endinterface

// File: rtl/sd_cmd_sequencer.sv
// sd_cmd_sequencer: issues the register-write burst for one SD command, polls
// NISR/EISR until the command (and optional data phase) completes, times out
// or the poll watchdog expires, then reports done/error and the response.
// Optional feature macro SEQ_RESP_READ_EN: when defined, R0R/R1R are read into
// 'response' before done; when undefined, response stays 0.
module sd_cmd_sequencer #(
    parameter int POLL_GAP = 4,
    parameter int POLL_MAX = 1024
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               start,
    input  logic [5:0]         cmd_index,
    input  logic [31:0]        cmd_arg,
    input  logic               data_present,
    input  logic [11:0]        blk_size,
    input  logic [15:0]        blk_cnt,
    input  logic               multi_blk,
    input  logic               direction,
    input  logic [31:0]        adma_addr,
    sd_cmd_sequencer_if.master bus,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [1:0]         err_code,
    output logic [31:0]        response,
    output logic [4:0]         state_dbg
);

    typedef enum logic [4:0] {
        IDLE, WR_ADMA, WR_BSR, WR_BCR, WR_A0, WR_A1, WR_TMR, WR_CR,
        P_NISR, P_EISR, P_CHK, P_GAP,
        R0_RD, R0_CAP, R1_RD, R1_CAP,
        DONE, ERR
    } state_t;

    localparam logic [15:0] POLL_MAX_W = 16'(POLL_MAX);
    localparam logic [8:0]  POLL_GAP_W = 9'(POLL_GAP);

    state_t      state_q, state_d;
    logic [5:0]  idx_q, idx_d;
    logic [31:0] arg_q, arg_d;
    logic        dp_q, dp_d;
    logic [11:0] bsz_q, bsz_d;
    logic [15:0] bcnt_q, bcnt_d;
    logic        multi_q, multi_d;
    logic        dir_q, dir_d;
    logic [31:0] adma_q, adma_d;
    logic [15:0] poll_cnt_q, poll_cnt_d;
    logic [7:0]  gap_cnt_q, gap_cnt_d;
    logic        phase_q, phase_d;       // 0 = CMD poll, 1 = DAT poll
    logic        nisr_hit_q, nisr_hit_d; // NISR completion bit of this iteration
    logic [1:0]  err_code_q, err_code_d;
    logic [31:0] response_q, response_d;

    logic [15:0] poll_inc;
    logic [7:0]  gap_inc;

    // Both counters saturate instead of wrapping.
    assign poll_inc = (poll_cnt_q == 16'hFFFF) ? poll_cnt_q : poll_cnt_q + 16'd1;
    assign gap_inc  = (gap_cnt_q == 8'hFF) ? gap_cnt_q : gap_cnt_q + 8'd1;

    assign busy      = !(state_q inside {IDLE, DONE, ERR});
    assign done      = (state_q == DONE);
    assign error     = (state_q == ERR);
    assign err_code  = err_code_q;
    assign response  = response_q;
    assign state_dbg = state_q;

`ifdef SEQ_RESP_READ_EN
    logic unused_rd_hi;
    assign unused_rd_hi = ^bus.reg_rd_data[31:16];
`else
    logic unused_rd_hi;
    assign unused_rd_hi = ^bus.reg_rd_data[31:2];
`endif

    // State and datapath registers with synchronous active-high reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            arg_q      <= '0;
            dp_q       <= 1'b0;
            bsz_q      <= '0;
            bcnt_q     <= '0;
            multi_q    <= 1'b0;
            dir_q      <= 1'b0;
            adma_q     <= '0;
            poll_cnt_q <= '0;
            gap_cnt_q  <= '0;
            phase_q    <= 1'b0;
            nisr_hit_q <= 1'b0;
            err_code_q <= 2'b00;
            response_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            arg_q      <= arg_d;
            dp_q       <= dp_d;
            bsz_q      <= bsz_d;
            bcnt_q     <= bcnt_d;
            multi_q    <= multi_d;
            dir_q      <= dir_d;
            adma_q     <= adma_d;
            poll_cnt_q <= poll_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            phase_q    <= phase_d;
            nisr_hit_q <= nisr_hit_d;
            err_code_q <= err_code_d;
            response_q <= response_d;
        end
    end

    // Next-state, register-bus outputs and datapath updates.
    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        arg_d           = arg_q;
        dp_d            = dp_q;
        bsz_d           = bsz_q;
        bcnt_d          = bcnt_q;
        multi_d         = multi_q;
        dir_d           = dir_q;
        adma_d          = adma_q;
        poll_cnt_d      = poll_cnt_q;
        gap_cnt_d       = gap_cnt_q;
        phase_d         = phase_q;
        nisr_hit_d      = nisr_hit_q;
        err_code_d      = err_code_q;
        response_d      = response_q;
        bus.req         = 1'b0;
        bus.reg_wr_en   = 1'b0;
        bus.reg_address = 12'h000;
        bus.reg_wr_data = 32'h0;

        case (state_q)
            // busy=0 in DONE/ERR too, so a start there is accepted like in IDLE.
            IDLE, DONE, ERR: begin
                state_d = IDLE;
                if (start) begin
                    idx_d      = cmd_index;
                    arg_d      = cmd_arg;
                    dp_d       = data_present;
                    bsz_d      = blk_size;
                    bcnt_d     = blk_cnt;
                    multi_d    = multi_blk;
                    dir_d      = direction;
                    adma_d     = adma_addr;
                    err_code_d = 2'b00;
                    response_d = '0;
                    state_d    = data_present ? WR_ADMA : WR_A0;
                end
            end
            WR_ADMA: begin
                bus.req = 1'b1; bus.reg_wr_en = 1'b1;
                bus.reg_address = 12'h054;
                bus.reg_wr_data = adma_q;
                state_d = WR_BSR;
            end
            WR_BSR: begin
                bus.req = 1'b1; bus.reg_wr_en = 1'b1;
                bus.reg_address = 12'h004;
                bus.reg_wr_data = {20'h0, bsz_q};
                state_d = WR_BCR;
            end
            WR_BCR: begin
                bus.req = 1'b1; bus.reg_wr_en = 1'b1;
                bus.reg_address = 12'h006;
                bus.reg_wr_data = {16'h0, bcnt_q};
                state_d = WR_A0;
            end
            WR_A0: begin
                bus.req = 1'b1; bus.reg_wr_en = 1'b1;
                bus.reg_address = 12'h008;
                bus.reg_wr_data = {16'h0, arg_q[15:0]};
                state_d = WR_A1;
            end
            WR_A1: begin
                bus.req = 1'b1; bus.reg_wr_en = 1'b1;
                bus.reg_address = 12'h00A;
                bus.reg_wr_data = {16'h0, arg_q[31:16]};
                state_d = WR_TMR;
            end
            WR_TMR: begin
                bus.req = 1'b1; bus.reg_wr_en = 1'b1;
                bus.reg_address = 12'h00C;
                bus.reg_wr_data = {16'h0, 10'b0, multi_q, dir_q, 4'b0};
                state_d = WR_CR;
            end
            // The CR write launches the command, so it is always last.
            WR_CR: begin
                bus.req = 1'b1; bus.reg_wr_en = 1'b1;
                bus.reg_address = 12'h00E;
                bus.reg_wr_data = {16'h0, 2'b00, idx_q, 2'b00, dp_q, 5'b0};
                poll_cnt_d = '0;
                phase_d    = 1'b0;
                state_d    = P_NISR;
            end
            P_NISR: begin
                bus.req = 1'b1;
                bus.reg_address = 12'h030;
                poll_cnt_d = poll_inc;
                state_d    = P_EISR;
            end
            // NISR data returns while EISR is being requested.
            P_EISR: begin
                bus.req = 1'b1;
                bus.reg_address = 12'h032;
                nisr_hit_d = phase_q ? bus.reg_rd_data[1] : bus.reg_rd_data[0];
                state_d    = P_CHK;
            end
            // Decision cycle; it is also the first of the POLL_GAP idle cycles.
            // Checking after EISR lets a timeout beat a same-iteration complete.
            P_CHK: begin
                gap_cnt_d = 8'd1;
                if (bus.reg_rd_data[0]) begin
                    err_code_d = 2'b01;
                    state_d    = ERR;
                end else if (nisr_hit_q) begin
                    if (!phase_q && dp_q) begin
                        phase_d    = 1'b1;
                        poll_cnt_d = '0;
                        state_d    = P_NISR;
                    end else begin
`ifdef SEQ_RESP_READ_EN
                        state_d = R0_RD;
`else
                        state_d = DONE;
`endif
                    end
                end else if (poll_cnt_q == POLL_MAX_W) begin
                    err_code_d = 2'b10;
                    state_d    = ERR;
                end else if (POLL_GAP_W <= 9'd1) begin
                    state_d = P_NISR;
                end else begin
                    state_d = P_GAP;
                end
            end
            P_GAP: begin
                gap_cnt_d = gap_inc;
                if ({1'b0, gap_inc} >= POLL_GAP_W) begin
                    state_d = P_NISR;
                end
            end
`ifdef SEQ_RESP_READ_EN
            R0_RD: begin
                bus.req = 1'b1;
                bus.reg_address = 12'h010;
                state_d = R0_CAP;
            end
            R0_CAP: begin
                response_d[15:0] = bus.reg_rd_data[15:0];
                state_d = R1_RD;
            end
            R1_RD: begin
                bus.req = 1'b1;
                bus.reg_address = 12'h012;
                state_d = R1_CAP;
            end
            R1_CAP: begin
                response_d[31:16] = bus.reg_rd_data[15:0];
                state_d = DONE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// Testbench for sd_cmd_sequencer: directed command scenarios against a
// cycle-trace model of the register-port protocol, plus literal expectations.
// Honours SEQ_RESP_READ_EN the same way the design does.
module tb_sd_cmd_sequencer;

    localparam int GAP   = 3;
    localparam int PMAX  = 8;
    localparam int NEVER = 100000;

`ifdef SEQ_RESP_READ_EN
    localparam bit RESP_EN = 1'b1;
`else
    localparam bit RESP_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic CLK = 1'b0;
    logic RESET = 1'b1;
    always #5 CLK = ~CLK;

    logic        start = 1'b0;
    logic [5:0]  cmd_index = '0;
    logic [31:0] cmd_arg = '0;
    logic        data_present = 1'b0;
    logic [11:0] blk_size = '0;
    logic [15:0] blk_cnt = '0;
    logic        multi_blk = 1'b0;
    logic        direction = 1'b0;
    logic [31:0] adma_addr = '0;
    logic        busy, done, error;
    logic [1:0]  err_code;
    logic [31:0] response;
    logic [4:0]  state_dbg;

    sd_cmd_sequencer_if bus ();

    sd_cmd_sequencer #(.POLL_GAP(GAP), .POLL_MAX(PMAX)) dut (
        .CLK(CLK), .RESET(RESET), .start(start),
        .cmd_index(cmd_index), .cmd_arg(cmd_arg), .data_present(data_present),
        .blk_size(blk_size), .blk_cnt(blk_cnt), .multi_blk(multi_blk),
        .direction(direction), .adma_addr(adma_addr), .bus(bus.master),
        .busy(busy), .done(done), .error(error), .err_code(err_code),
        .response(response), .state_dbg(state_dbg)
    );

    // ---------------- model state ----------------
    typedef struct packed {
        logic        req;
        logic        wr;
        logic [11:0] addr;
        logic [31:0] data;
        logic        busy;
        logic        done;
        logic        err;
        logic [1:0]  ec;
        logic [31:0] rsp;
    } cyc_t;
    localparam int CW = $bits(cyc_t);

    logic [CW-1:0] exp_q[$];
    logic [43:0]   wlog[$];
    logic [11:0]   rlog[$];
    int checks = 0;
    int errors = 0;
    logic go = 1'b0;

    // Status behaviour of the register slave for the current scenario:
    // NISR[0] from the sc_cmd_iter-th NISR read, NISR[1] from read
    // sc_cmd_iter+sc_dat_iter, EISR[0] from read sc_eisr_iter (0 = never).
    int          sc_cmd_iter = NEVER;
    int          sc_dat_iter = NEVER;
    int          sc_eisr_iter = 0;
    logic [15:0] sc_r0 = '0;
    logic [15:0] sc_r1 = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp_v);
        end
    endtask

    function automatic void push_cyc(input logic r, input logic w, input logic [11:0] a,
                                     input logic [31:0] d, input logic b, input logic dn,
                                     input logic er, input logic [1:0] ec, input logic [31:0] rsp);
        cyc_t c;
        c.req = r; c.wr = w; c.addr = a; c.data = d;
        c.busy = b; c.done = dn; c.err = er; c.ec = ec; c.rsp = rsp;
        exp_q.push_back(c);
    endfunction

    // Expected per-cycle trace of one transaction, from its first busy cycle.
    function automatic void build_trace(input logic dp, input logic [5:0] idx, input logic [31:0] arg,
                                        input logic [11:0] bsz, input logic [15:0] bcnt,
                                        input logic mb, input logic dir, input logic [31:0] adma);
        int n;
        int it;
        int result;
        logic [1:0]  ec;
        logic [31:0] rsp;
        logic hit, eisr, resolved;
        if (dp) begin
            push_cyc(1, 1, 12'h054, adma, 1, 0, 0, 0, 0);
            push_cyc(1, 1, 12'h004, 32'(bsz), 1, 0, 0, 0, 0);
            push_cyc(1, 1, 12'h006, 32'(bcnt), 1, 0, 0, 0, 0);
        end
        push_cyc(1, 1, 12'h008, arg % 65536, 1, 0, 0, 0, 0);
        push_cyc(1, 1, 12'h00A, arg / 65536, 1, 0, 0, 0, 0);
        push_cyc(1, 1, 12'h00C, 32'(mb) * 32 + 32'(dir) * 16, 1, 0, 0, 0, 0);
        push_cyc(1, 1, 12'h00E, 32'(idx) * 256 + 32'(dp) * 32, 1, 0, 0, 0, 0);
        n = 0; result = 0; ec = 2'b00;
        for (int ph = 0; ph <= int'(dp) && result == 0; ph++) begin
            it = 0; resolved = 1'b0;
            while (!resolved && result == 0) begin
                it++; n++;
                push_cyc(1, 0, 12'h030, 0, 1, 0, 0, 0, 0);
                push_cyc(1, 0, 12'h032, 0, 1, 0, 0, 0, 0);
                push_cyc(0, 0, 0, 0, 1, 0, 0, 0, 0);
                eisr = (sc_eisr_iter != 0) && (n >= sc_eisr_iter);
                hit  = (ph == 0) ? (n >= sc_cmd_iter) : (n >= sc_cmd_iter + sc_dat_iter);
                if (eisr) begin
                    result = 2; ec = 2'b01;
                end else if (hit) begin
                    resolved = 1'b1;
                end else if (it == PMAX) begin
                    result = 2; ec = 2'b10;
                end else begin
                    for (int g = 1; g < GAP; g++) push_cyc(0, 0, 0, 0, 1, 0, 0, 0, 0);
                end
            end
        end
        if (result == 0) begin
            rsp = '0;
            if (RESP_EN) begin
                push_cyc(1, 0, 12'h010, 0, 1, 0, 0, 0, 0);
                push_cyc(0, 0, 0, 0, 1, 0, 0, 0, 0);
                push_cyc(1, 0, 12'h012, 0, 1, 0, 0, 0, 0);
                push_cyc(0, 0, 0, 0, 1, 0, 0, 0, 0);
                rsp = {sc_r1, sc_r0};
            end
            push_cyc(0, 0, 0, 0, 0, 1, 0, 2'b00, rsp);
        end else begin
            push_cyc(0, 0, 0, 0, 0, 0, 1, ec, 32'h0);
        end
    endfunction

    // ---------------- register slave ----------------
    int          nisr_n = 0;
    logic [31:0] pend;
    initial bus.reg_rd_data = 32'hFFFF_FFFF;

    // Answers reads one cycle later; all-ones otherwise, so a mistimed sample shows up.
    always begin
        @(negedge CLK);
        pend = 32'hFFFF_FFFF;
        if (RESET) begin
            nisr_n = 0;
        end else if (bus.req === 1'b1) begin
            if (bus.reg_wr_en === 1'b1) begin
                if (bus.reg_address == 12'h00E) nisr_n = 0;
            end else begin
                case (bus.reg_address)
                    12'h030: begin
                        nisr_n++;
                        pend = {30'h0, nisr_n >= sc_cmd_iter + sc_dat_iter, nisr_n >= sc_cmd_iter};
                    end
                    12'h032: pend = {31'h0, (sc_eisr_iter != 0) && (nisr_n >= sc_eisr_iter)};
                    12'h010: pend = {16'hBEEF, sc_r0};
                    12'h012: pend = {16'hCAFE, sc_r1};
                    default: pend = 32'hFFFF_FFFF;
                endcase
            end
        end
        @(posedge CLK);
        #1;
        bus.reg_rd_data = pend;
    end

    // ---------------- scoreboard compare ----------------
    cyc_t ce;
    logic cok;
    always begin
        @(negedge CLK);
        if (go) begin
            if (exp_q.size() > 0) ce = exp_q.pop_front();
            else ce = '0;
            cok = (bus.req === ce.req) && (busy === ce.busy) && (done === ce.done) && (error === ce.err);
            if (ce.req) cok = cok && (bus.reg_address === ce.addr) && (bus.reg_wr_en === ce.wr);
            if (ce.req && ce.wr) cok = cok && (bus.reg_wr_data === ce.data);
            if (ce.done || ce.err) cok = cok && (err_code === ce.ec) && (response === ce.rsp);
            checks++;
            if (!cok) begin
                errors++;
                $display("FAIL cycle t=%0t actual req=%b we=%b adr=%h wd=%h busy=%b done=%b err=%b ec=%b rsp=%h required req=%b we=%b adr=%h wd=%h busy=%b done=%b err=%b ec=%b rsp=%h",
                         $time, bus.req, bus.reg_wr_en, bus.reg_address, bus.reg_wr_data, busy, done, error, err_code, response,
                         ce.req, ce.wr, ce.addr, ce.data, ce.busy, ce.done, ce.err, ce.ec, ce.rsp);
            end
            if (bus.req === 1'b1) begin
                if (bus.reg_wr_en === 1'b1) wlog.push_back({bus.reg_address, bus.reg_wr_data});
                else rlog.push_back(bus.reg_address);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic run_txn(input logic dp, input logic [5:0] idx, input logic [31:0] arg,
                           input logic [11:0] bsz, input logic [15:0] bcnt, input logic mb,
                           input logic dir, input logic [31:0] adma,
                           input int busy_start_at, input int reset_at, output int end_cyc);
        int cyc;
        logic fin;
        end_cyc = 0;
        wlog.delete();
        rlog.delete();
        @(negedge CLK);
        #1;
        start = 1'b1; data_present = dp; cmd_index = idx; cmd_arg = arg;
        blk_size = bsz; blk_cnt = bcnt; multi_blk = mb; direction = dir; adma_addr = adma;
        build_trace(dp, idx, arg, bsz, bcnt, mb, dir, adma);
        cyc = 0;
        fin = 1'b0;
        while (!fin) begin
            @(negedge CLK);
            #1;
            cyc++;
            start = 1'b0;
            // Scrambled inputs after acceptance must not reach the bus.
            data_present = ~dp; cmd_index = ~idx; cmd_arg = ~arg; blk_size = ~bsz;
            blk_cnt = ~bcnt; multi_blk = ~mb; direction = ~dir; adma_addr = ~adma;
            if ((done === 1'b1 || error === 1'b1) && end_cyc == 0) end_cyc = cyc;
            if (cyc == busy_start_at) start = 1'b1;
            if (reset_at != 0 && cyc == reset_at) begin
                RESET = 1'b1;
                exp_q.delete();
            end else if (reset_at != 0 && cyc == reset_at + 1) begin
                check("rst_req_low", 64'(bus.req), 64'h0);
                check("rst_busy_low", 64'(busy), 64'h0);
                check("rst_state_outputs", {err_code, response}, 64'h0);
                RESET = 1'b0;
                fin = 1'b1;
            end
            if (reset_at == 0 && exp_q.size() == 0) fin = 1'b1;
            if (cyc > 3000) begin
                checks++;
                errors++;
                $display("FAIL txn_timeout actual=no_completion required=completion_within_3000_cycles");
                exp_q.delete();
                fin = 1'b1;
            end
        end
    endtask

    function automatic int count_reads(input logic [11:0] a);
        int c;
        c = 0;
        foreach (rlog[i]) if (rlog[i] == a) c++;
        return c;
    endfunction

    // ---------------- directed scenarios ----------------
    int dc;
    logic [43:0] t1w [4];
    logic [43:0] t2w [7];

    initial begin
        t1w = '{{12'h008, 32'h01AA}, {12'h00A, 32'h0000}, {12'h00C, 32'h0000}, {12'h00E, 32'h0800}};
        t2w = '{{12'h054, 32'h1000}, {12'h004, 32'h0200}, {12'h006, 32'h0004}, {12'h008, 32'h5678},
                {12'h00A, 32'h1234}, {12'h00C, 32'h0030}, {12'h00E, 32'h1120}};

        // Reset state
        repeat (3) @(negedge CLK);
        check("reset_req", 64'(bus.req), 64'h0);
        check("reset_flags", {busy, done, error}, 64'h0);
        check("reset_err_code", 64'(err_code), 64'h0);
        check("reset_response", 64'(response), 64'h0);
        #1;
        RESET = 1'b0;
        go = 1'b1;

        // 1: non-data command, complete on 3rd poll
        sc_cmd_iter = 3; sc_dat_iter = NEVER; sc_eisr_iter = 0; sc_r0 = 16'h0120; sc_r1 = 16'h0000;
        run_txn(1'b0, 6'd8, 32'h0000_01AA, 12'd0, 16'd0, 1'b0, 1'b0, 32'h0, 0, 0, dc);
        check("t1_done_cycle", 64'(dc), RESP_EN ? 64'd22 : 64'd18);
        check("t1_response", 64'(response), RESP_EN ? 64'h120 : 64'h0);
        check("t1_write_count", 64'(wlog.size()), 64'd4);
        foreach (t1w[i]) check("t1_write", 64'(wlog[i]), 64'(t1w[i]));

        // 2: data read command, start pulsed while busy
        sc_cmd_iter = 1; sc_dat_iter = 2; sc_eisr_iter = 0; sc_r0 = 16'h0900; sc_r1 = 16'h0001;
        run_txn(1'b1, 6'h11, 32'h1234_5678, 12'd512, 16'd4, 1'b1, 1'b1, 32'h0000_1000, 9, 0, dc);
        check("t2_done_cycle", 64'(dc), RESP_EN ? 64'd23 : 64'd19);
        check("t2_nisr_reads", 64'(count_reads(12'h030)), 64'd3);
        check("t2_response", 64'(response), RESP_EN ? 64'h0001_0900 : 64'h0);
        check("t2_write_count", 64'(wlog.size()), 64'd7);
        foreach (t2w[i]) check("t2_write", 64'(wlog[i]), 64'(t2w[i]));

        // 3: command timeout seen together with complete
        sc_cmd_iter = 2; sc_dat_iter = NEVER; sc_eisr_iter = 2;
        run_txn(1'b0, 6'd2, 32'h0, 12'd0, 16'd0, 1'b0, 1'b0, 32'h0, 0, 0, dc);
        check("t3_error_cycle", 64'(dc), 64'd13);
        check("t3_err_code", 64'(err_code), 64'h1);
        check("t3_resp_reads", 64'(count_reads(12'h010) + count_reads(12'h012)), 64'd0);

        // 4: watchdog
        sc_cmd_iter = NEVER; sc_dat_iter = NEVER; sc_eisr_iter = 0;
        run_txn(1'b0, 6'd13, 32'hFFFF_0000, 12'd0, 16'd0, 1'b1, 1'b0, 32'h0, 0, 0, dc);
        check("t4_nisr_reads", 64'(count_reads(12'h030)), 64'd8);
        check("t4_err_code", 64'(err_code), 64'h2);
        check("t4_error_cycle", 64'(dc), 64'd43);

        // 5: reset during WR_BCR, then a fresh full sequence
        sc_cmd_iter = 1; sc_dat_iter = 1; sc_eisr_iter = 0; sc_r0 = 16'h0A0B; sc_r1 = 16'h0C0D;
        run_txn(1'b1, 6'd18, 32'h0000_0200, 12'd512, 16'd2, 1'b0, 1'b1, 32'h0000_2000, 0, 3, dc);
        check("t5_writes_before_reset", 64'(wlog.size()), 64'd3);
        run_txn(1'b1, 6'd18, 32'h0000_0200, 12'd512, 16'd2, 1'b0, 1'b1, 32'h0000_2000, 0, 0, dc);
        check("t5_full_write_count", 64'(wlog.size()), 64'd7);
        check("t5_response", 64'(response), RESP_EN ? 64'h0C0D_0A0B : 64'h0);

        repeat (3) @(negedge CLK);
        go = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
